can_rx_deserializer: RTL

Receive-side bit engine of the CAN controller. It samples the raw `rxd` line, recovers bit timing and removes stuff bits. It assembles destuffed bits MSB-first into 32-bit words and pushes each word to the receive FIFO with a one-cycle `write_fifo` strobe. The CAN register/control block then drains that FIFO.

---
 rtl/can_rx_deserializer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/can_rx_deserializer.sv
// CAN receive bit engine: synchronizes rxd, recovers bit timing, removes stuff bits
// and packs data bits MSB-first into 32-bit FIFO words. Optional CAN_RX_RESYNC_EN adds soft resync.
module can_rx_deserializer #(
  parameter int BIT_TICKS    = 10,
  parameter int SAMPLE_POINT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rxd,
  output logic [31:0] rx_word,
  output logic [5:0]  rx_count,
  output logic        write_fifo,
  output logic        stuff_error,
  output logic        bus_idle
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [7:0] TICK_LAST = 8'(BIT_TICKS - 1);
  localparam logic [7:0] TICK_SMP  = 8'(SAMPLE_POINT);

  logic        sync1, rxs, rxs_prev;
  logic [7:0]  tick;
  logic [1:0]  state;
  logic [3:0]  rec_cnt;
  logic [2:0]  run_len;
  logic        prev_bit;
  logic [31:0] shift;
  logic [5:0]  bit_cnt;

  logic        fall, hard_sync, resync, sample;
  logic [31:0] shift_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall      = rxs_prev & ~rxs;
  assign hard_sync = (state == S_IDLE) && bus_idle && fall;
`ifdef CAN_RX_RESYNC_EN
  assign resync    = (state == S_RECV) && fall;
`else
  assign resync    = 1'b0;
`endif
  // A sync edge restarts the bit, so the stale sample position on that cycle is dropped.
  assign sample     = (tick == TICK_SMP) && !hard_sync && !resync;
  assign shift_next = {shift[30:0], rxs};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tick        <= '0;
      rec_cnt     <= '0;
      run_len     <= '0;
      prev_bit    <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      rx_word     <= '0;
      rx_count    <= '0;
      write_fifo  <= 1'b0;
      stuff_error <= 1'b0;
      bus_idle    <= 1'b0;
    end else if (!enable) begin
      state       <= S_IDLE;
      tick        <= '0;
      rec_cnt     <= '0;
      run_len     <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      write_fifo  <= 1'b0;
      stuff_error <= 1'b0;
      bus_idle    <= 1'b0;
    end else begin
      write_fifo <= 1'b0;
      tick       <= (hard_sync || resync || tick == TICK_LAST) ? 8'd0 : tick + 8'd1;

      case (state)
        S_IDLE: begin
          if (hard_sync) begin
            // run_len == 0 marks the SOF sample still to come
            state    <= S_RECV;
            bus_idle <= 1'b0;
            rec_cnt  <= '0;
            run_len  <= '0;
            prev_bit <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
          end else if (sample) begin
            if (rxs) begin
              if (rec_cnt != 4'd11) rec_cnt <= rec_cnt + 4'd1;
              bus_idle <= (rec_cnt >= 4'd10);
            end else begin
              rec_cnt  <= '0;
              bus_idle <= 1'b0;
            end
          end
        end

        S_RECV: begin
          if (sample) begin
            if (run_len == 3'd0) begin
              run_len  <= 3'd1;
              prev_bit <= rxs;
            end else if (run_len == 3'd5) begin
              if (rxs != prev_bit) begin
                run_len  <= 3'd1;
                prev_bit <= rxs;
              end else if (!rxs) begin
                stuff_error <= 1'b1;
                rec_cnt     <= '0;
                state       <= S_ERROR;
              end else begin
                state <= S_FLUSH;
              end
            end else begin
              run_len  <= (rxs == prev_bit) ? run_len + 3'd1 : 3'd1;
              prev_bit <= rxs;
              if (bit_cnt == 6'd31) begin
                write_fifo <= 1'b1;
                rx_word    <= shift_next;
                rx_count   <= 6'd32;
                shift      <= '0;
                bit_cnt    <= '0;
              end else begin
                shift   <= shift_next;
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
        end

        S_FLUSH: begin
          // shift is cleared on every push, so a partial word is already right-aligned
          if (bit_cnt != 6'd0) begin
            write_fifo <= 1'b1;
            rx_word    <= shift;
            rx_count   <= bit_cnt;
          end
          state    <= S_IDLE;
          rec_cnt  <= 4'd6;
          bus_idle <= 1'b0;
          shift    <= '0;
          bit_cnt  <= '0;
          run_len  <= '0;
        end

        default: begin
          if (sample) begin
            if (rxs) begin
              if (rec_cnt == 4'd10) begin
                state       <= S_IDLE;
                rec_cnt     <= '0;
                stuff_error <= 1'b0;
              end else begin
                rec_cnt <= rec_cnt + 4'd1;
              end
            end else begin
              rec_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule
